// File: rtl/wave_capture.sv
// Tick-decimated sample capture into a single-port RAM with valid/ready readback.
// Optional signed rising-edge level trigger: define WAVE_CAPTURE_TRIG_EN.
module wave_capture #(
    parameter int SAMP_WIDTH = 24,
    parameter int SAMP_DEPTH = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [15:0]                   i_phase_step,
    input  logic [SAMP_WIDTH-1:0]         i_samp,
    input  logic                          i_arm,
`ifdef WAVE_CAPTURE_TRIG_EN
    input  logic [SAMP_WIDTH-1:0]         i_trig_level,
`endif
    input  logic                          i_rd_start,
    input  logic                          i_rd_ready,
    output logic [SAMP_WIDTH-1:0]         o_rd_data,
    output logic                          o_rd_valid,
    output logic                          o_rd_last,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(SAMP_DEPTH):0]   o_count
);
    localparam int SAMP_ADDR = $clog2(SAMP_DEPTH);
    localparam logic [SAMP_ADDR:0] DEPTH_CNT = (SAMP_ADDR+1)'(SAMP_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DONE, ST_READOUT} state_t;

    state_t                state_q, state_d;
    logic [15:0]           div_q, div_d;
    logic [SAMP_ADDR:0]    count_q, count_d;
    logic [SAMP_ADDR:0]    rd_cnt_q, rd_cnt_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic [SAMP_WIDTH-1:0] rd_data_q;
`ifdef WAVE_CAPTURE_TRIG_EN
    logic [SAMP_WIDTH-1:0] prev_q, prev_d;
    logic                  have_prev_q, have_prev_d;
`endif

    logic                  tick;
    logic                  wr_en;
    logic                  rd_en;
    logic                  rd_pending;
    logic [SAMP_ADDR-1:0]  wr_addr;
    logic [SAMP_ADDR-1:0]  ram_addr;
    logic [SAMP_WIDTH-1:0] mem [SAMP_DEPTH];

    assign tick       = (div_q == i_phase_step);
    assign div_d      = tick ? 16'd0 : div_q + 16'd1;
    assign rd_pending = (rd_cnt_q != DEPTH_CNT);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_cnt_d   = rd_cnt_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        wr_en      = 1'b0;
        wr_addr    = count_q[SAMP_ADDR-1:0];
        rd_en      = 1'b0;
`ifdef WAVE_CAPTURE_TRIG_EN
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_arm) begin
                    count_d = '0;
`ifdef WAVE_CAPTURE_TRIG_EN
                    have_prev_d = 1'b0;
                    state_d     = ST_ARMED;
`else
                    state_d     = ST_CAPTURE;
`endif
                end else if (state_q == ST_DONE && i_rd_start) begin
                    rd_cnt_d   = '0;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    state_d    = ST_READOUT;
                end
            end
`ifdef WAVE_CAPTURE_TRIG_EN
            ST_ARMED: begin
                // The first tick after arming only primes prev_q
                if (tick) begin
                    if (have_prev_q && ($signed(prev_q) < $signed(i_trig_level)) &&
                        ($signed(i_samp) >= $signed(i_trig_level))) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        count_d = (SAMP_ADDR+1)'(1);
                        state_d = ST_CAPTURE;
                    end else begin
                        prev_d      = i_samp;
                        have_prev_d = 1'b1;
                    end
                end
            end
`endif
            ST_CAPTURE: begin
                if (tick) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == DEPTH_CNT - 1'b1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READOUT: begin
                // RAM read register doubles as the output stage; it only advances when free
                if (!rd_valid_q || i_rd_ready) begin
                    rd_en      = rd_pending;
                    rd_valid_d = rd_pending;
                    rd_last_d  = (rd_cnt_q == DEPTH_CNT - 1'b1);
                    if (rd_pending) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
                if (rd_valid_q && i_rd_ready && rd_last_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_addr = wr_en ? wr_addr : rd_cnt_q[SAMP_ADDR-1:0];

    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            mem[ram_addr] <= i_samp;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            count_q     <= '0;
            rd_cnt_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
`ifdef WAVE_CAPTURE_TRIG_EN
            prev_q      <= '0;
            have_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            count_q     <= count_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
`ifdef WAVE_CAPTURE_TRIG_EN
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
`endif
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_rd_last  = rd_last_q & rd_valid_q;
    assign o_busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) || (state_q == ST_READOUT);
    assign o_done     = (state_q == ST_DONE);
    assign o_count    = count_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: a cycle model pushes captured samples to a
// scoreboard queue, and readout handshakes pop and compare them.
module tb_wave_capture;
    localparam int W = 24;
    localparam int D = 8;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [15:0]  i_phase_step;
    logic [W-1:0] i_samp;
    logic         i_arm;
    logic         i_rd_start;
    logic         i_rd_ready;
`ifdef WAVE_CAPTURE_TRIG_EN
    logic [W-1:0] i_trig_level;
`endif
    logic [W-1:0] o_rd_data;
    logic         o_rd_valid;
    logic         o_rd_last;
    logic         o_busy;
    logic         o_done;
    logic [3:0]   o_count;

    always #5 i_clk = ~i_clk;

    wave_capture #(.SAMP_WIDTH(W), .SAMP_DEPTH(D)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_phase_step (i_phase_step),
        .i_samp       (i_samp),
        .i_arm        (i_arm),
`ifdef WAVE_CAPTURE_TRIG_EN
        .i_trig_level (i_trig_level),
`endif
        .i_rd_start   (i_rd_start),
        .i_rd_ready   (i_rd_ready),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .o_rd_last    (o_rd_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_count      (o_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    // model state: 0 idle, 1 armed, 2 capture, 3 done, 4 readout
    int m_state = 0;
    int m_cnt = 0;
    int m_div = 0;
    logic signed [W-1:0] m_prev = '0;
    bit  m_have = 1'b0;
    int  cur_lvl = 0;
    int  samp_mode = 0;
    int  ramp = 0;
    int  first_rd = -1;
    int  t_mark = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rd_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".busy"},  32'(o_busy),  32'(m_state == 1 || m_state == 2 || m_state == 4));
        chk({tag, ".done"},  32'(o_done),  32'(m_state == 3));
        chk({tag, ".count"}, 32'(o_count), 32'(m_cnt));
    endtask

    // Advance one clock: update the model from the inputs seen at this edge.
    task automatic clk1();
        bit tick;
        logic [W-1:0] lvl;
        lvl  = W'(cur_lvl);
        tick = (m_div == int'(i_phase_step));
        if (i_rst) begin
            m_state = 0; m_cnt = 0; m_div = 0; tick = 1'b0;
        end else begin
            m_div = tick ? 0 : m_div + 1;
            case (m_state)
                1: if (tick) begin
                    if (m_have && (m_prev < $signed(lvl)) && ($signed(i_samp) >= $signed(lvl))) begin
                        exp_q.push_back(i_samp); m_cnt = 1; m_state = 2;
                    end else begin
                        m_prev = $signed(i_samp); m_have = 1'b1;
                    end
                end
                2: if (tick) begin
                    exp_q.push_back(i_samp); m_cnt++;
                    if (m_cnt == D) m_state = 3;
                end
                0, 3: if (i_arm) begin
`ifdef WAVE_CAPTURE_TRIG_EN
                    m_state = 1;
`else
                    m_state = 2;
`endif
                    m_cnt = 0; m_have = 1'b0; exp_q.delete();
                end else if (m_state == 3 && i_rd_start) begin
                    m_state = 4;
                end
                default: ;
            endcase
        end
        @(posedge i_clk);
        #1;
        cyc++;
        if (samp_mode == 0) i_samp = W'(cyc);
        else if (samp_mode == 1 && tick) begin ramp++; i_samp = W'(ramp); end
    endtask

    task automatic arm(input int lvl);
        cur_lvl = lvl;
`ifdef WAVE_CAPTURE_TRIG_EN
        i_trig_level = W'(cur_lvl);
`endif
        i_arm = 1'b1;
        clk1();
        i_arm = 1'b0;
        chk("arm.busy", 32'(o_busy), 32'd1);
        chk_state("arm");
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && m_state != 3; i++) begin
            clk1();
            chk_state("cap");
        end
        chk("cap.done", 32'(o_done), 32'd1);
        chk("cap.count_full", 32'(o_count), 32'(D));
    endtask

    task automatic readout(input int mode);
        logic [W-1:0] held;
        logic [W-1:0] ev;
        bit stalled;
        bit pat [4];
        int hs, iters, first_v;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rd_q = exp_q;
        i_rd_start = 1'b1;
        i_rd_ready = 1'b1;
        clk1();
        i_rd_start = 1'b0;
        chk("rd.valid_t1", 32'(o_rd_valid), 32'd0);
        hs = 0; iters = 0; stalled = 1'b0; first_v = -1;
        for (int k = 0; k < 200 && hs < D; k++) begin
            i_rd_ready = (mode == 0) ? 1'b1 : pat[k % 4];
            if (o_rd_valid === 1'b1 && first_v < 0) first_v = k;
            if (stalled) begin
                chk("rd.hold_valid", 32'(o_rd_valid), 32'd1);
                chk("rd.hold_data", 32'(o_rd_data), 32'(held));
            end
            if (o_rd_valid === 1'b1 && i_rd_ready) begin
                ev = rd_q.pop_front();
                hs++;
                if (hs == 1) first_rd = int'($signed(o_rd_data));
                chk("rd.data", 32'(o_rd_data), 32'(ev));
                chk("rd.last", 32'(o_rd_last), 32'(hs == D));
                stalled = 1'b0;
            end else if (o_rd_valid === 1'b1) begin
                held = o_rd_data;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            clk1();
            iters++;
            if (hs == D) m_state = 3;
            chk_state("rd");
        end
        chk("rd.handshakes", 32'(hs), 32'(D));
        chk("rd.first_valid", 32'(first_v), 32'd1);
        if (mode == 0) chk("rd.no_bubble", 32'(iters), 32'(D + 1));
        chk("rd.valid_end", 32'(o_rd_valid), 32'd0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clk1();
        clk1();
        i_rst = 1'b0;
        chk("rst.valid", 32'(o_rd_valid), 32'd0);
        chk("rst.last", 32'(o_rd_last), 32'd0);
        chk("rst.data", 32'(o_rd_data), 32'd0);
        chk_state("rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_arm = 1'b0; i_rd_start = 1'b0; i_rd_ready = 1'b0;
        i_phase_step = 16'd3; i_samp = '0;
`ifdef WAVE_CAPTURE_TRIG_EN
        i_trig_level = '0;
`endif
        do_reset();

        // Untriggered capture, divider 3, arm at cycle 10
        while (cyc < 10) begin clk1(); chk_state("idle"); end
        arm(cyc + 6);
        wait_done(200);
`ifndef WAVE_CAPTURE_TRIG_EN
        chk("cap.done_cycle", 32'(cyc), 32'd42);
        chk("cap.first_sample", 32'(exp_q[0]), 32'd13);
`endif
        readout(0);
        readout(1);

        // arm and rd_start together in DONE: arm wins
        cur_lvl = cyc + 6;
`ifdef WAVE_CAPTURE_TRIG_EN
        i_trig_level = W'(cur_lvl);
`endif
        i_arm = 1'b1; i_rd_start = 1'b1;
        clk1();
        i_arm = 1'b0; i_rd_start = 1'b0;
        for (int i = 0; i < 200 && !(m_state == 2 && m_cnt >= 3); i++) begin
            chk("both.no_valid", 32'(o_rd_valid), 32'd0);
            chk_state("both");
            clk1();
        end
        // arm during capture is ignored
        t_mark = m_cnt;
        i_arm = 1'b1;
        clk1();
        i_arm = 1'b0;
        chk_state("arm_ign");
        chk("arm_ign.busy", 32'(o_busy), 32'd1);
        wait_done(200);
        readout(0);

        // Reset on the 4th write, then a clean capture
        arm(cyc + 6);
        for (int i = 0; i < 200 && !(m_state == 2 && m_cnt == 3 && m_div == int'(i_phase_step)); i++) begin
            clk1();
            chk_state("pre_rst");
        end
        i_rst = 1'b1;
        clk1();
        i_rst = 1'b0;
        chk("rst_mid.count", 32'(o_count), 32'd0);
        chk("rst_mid.busy", 32'(o_busy), 32'd0);
        chk("rst_mid.valid", 32'(o_rd_valid), 32'd0);
        chk_state("rst_mid");
        arm(cyc + 6);
        wait_done(200);
        readout(1);

        // Divider 0: one write per cycle
        i_phase_step = 16'd0;
        do_reset();
        t_mark = cyc;
        arm(cyc + 6);
        wait_done(200);
`ifndef WAVE_CAPTURE_TRIG_EN
        chk("ps0.cycles", 32'(cyc - t_mark), 32'(D + 1));
`endif
        readout(0);

`ifdef WAVE_CAPTURE_TRIG_EN
        // Rising crossing of level 0 on a -5.. ramp
        i_phase_step = 16'd1;
        do_reset();
        samp_mode = 1; ramp = -5; i_samp = W'(ramp);
        arm(0);
        wait_done(300);
        readout(0);
        chk("trig.addr0", 32'(first_rd), 32'd0);
        // Stream already above level never fires
        samp_mode = 2; i_samp = W'(5);
        arm(0);
        for (int i = 0; i < 40; i++) begin clk1(); chk_state("no_fire"); end
        chk("no_fire.busy", 32'(o_busy), 32'd1);
        chk("no_fire.count", 32'(o_count), 32'd0);
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wave_capture.md
# wave_capture

Sample-capture block sitting at the output end of the FIR test chain. It decimates an incoming sample stream with the same phase-step tick divider the noise/sine source uses and, after an arm (and optionally a level trigger), writes SAMP_DEPTH consecutive samples into an internal single-port RAM. It then streams the buffer out over a valid/ready interface for host readback or scope display.

## Interface
- SAMP_WIDTH, 24, sample width in bits, two's complement.
- SAMP_DEPTH, 1024, capture length in samples; must be a power of two, >= 4. SAMP_ADDR = $clog2(SAMP_DEPTH).
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_phase_step  input  16  tick divider terminal count. One tick every i_phase_step+1 cycles.
- i_samp  input  SAMP_WIDTH  sample under capture. Sampled only on tick cycles.
- i_arm  input  1  single-cycle pulse that starts a capture.
- i_trig_level  input  SAMP_WIDTH  signed rising-edge trigger threshold. Present only with WAVE_CAPTURE_TRIG_EN.
- i_rd_start  input  1  single-cycle pulse that starts a readout.
- i_rd_ready  input  1  downstream ready.
- o_rd_data  output  SAMP_WIDTH  readout sample.
- o_rd_valid  output  1  o_rd_data is valid.
- o_rd_last  output  1  marks the final readout sample; qualified by o_rd_valid.
- o_busy  output  1  high in ARMED, CAPTURE and READOUT.
- o_done  output  1  high in DONE.
- o_count  output  SAMP_ADDR+1  number of samples written in the current or last capture.

## Operation
- Divider: 16-bit counter, free-running from reset. tick = (count == i_phase_step), and the counter clears on tick. i_phase_step = 0 gives a tick every cycle.
- FSM states: IDLE, ARMED, CAPTURE, DONE, READOUT.
- IDLE/DONE + i_arm → ARMED (with trigger) or CAPTURE (without trigger). o_count clears to 0.
- ARMED: on each tick, register the previous tick's sample. A trigger fires when prev < i_trig_level and i_samp >= i_trig_level (signed compare). The very first tick after arming only loads prev and cannot fire. When the trigger fires, the triggering sample is written to address 0, o_count becomes 1, and the state moves to CAPTURE.
- CAPTURE: each tick writes i_samp to address o_count and increments o_count. On the write that makes o_count == SAMP_DEPTH, move to DONE.
- DONE + i_rd_start → READOUT. If i_arm and i_rd_start arrive in the same cycle, i_arm wins.
- READOUT: stream addresses 0..SAMP_DEPTH-1 in order.
  - o_rd_data must be held stable while o_rd_valid && !i_rd_ready. A skid register or read-ahead covers the one-cycle RAM read latency.
  - o_rd_last is high with the address SAMP_DEPTH-1 sample.
  - After the last handshake, return to DONE. A capture can be re-read any number of times.
- Ignored inputs:
  - i_arm in ARMED, CAPTURE and READOUT.
  - i_rd_start in every state except DONE.
  - Ticks outside ARMED and CAPTURE.
- Full/wrap: the write address never exceeds SAMP_DEPTH-1, and a capture never wraps.

## Timing
- Reset: state IDLE, divider 0, o_count 0. o_rd_valid, o_rd_last, o_busy and o_done are all 0, and o_rd_data is 0. RAM contents are not cleared.
- Reset asserted mid-capture or mid-readout aborts immediately. All outputs take their reset values in the cycle after the i_rst edge.
- i_arm at cycle t: o_busy = 1 from t+1.
- RAM write happens in the tick cycle itself. o_count is updated at the next edge.
- Final write at cycle t: o_done = 1 and o_busy = 0 from t+1.
- i_rd_start at cycle t: o_rd_valid first asserts at t+2. With i_rd_ready held high, one sample is delivered per cycle with no bubbles.
- Last handshake at cycle t: o_rd_valid = 0 and o_done = 1 at t+1.

## Configuration
- WAVE_CAPTURE_TRIG_EN defined: the ARMED state, the i_trig_level port and the rising-crossing trigger exist.
- Not defined: i_trig_level is absent and i_arm goes directly to CAPTURE. The first tick after the arm is written to address 0.

## Test plan
- Divider + untriggered capture (macro off, SAMP_DEPTH=8, i_phase_step=3, i_samp = cycle counter):
  - arm at cycle 10 → writes on ticks every 4 cycles.
  - o_done rises 1 cycle after the 8th write; o_count = 8.
  - readout returns the 8 tick-sampled values in order, o_rd_last on the 8th.
- Trigger (macro on, level = 0, i_samp ramp -5..+5 one step per tick):
  - address 0 holds 0, the first sample >= 0 after a negative one.
  - a stream already at +5 when armed never fires, and the block stays ARMED.
- Backpressure: toggle i_rd_ready 1,0,0,1,… during readout → o_rd_data constant across stalls, no samples lost or duplicated, exactly 8 handshakes.
- Simultaneous events:
  - i_arm + i_rd_start together in DONE → enters capture, no o_rd_valid.
  - i_arm during CAPTURE → o_count continues unchanged.
- Reset mid-op: assert i_rst at write 4 of 8 → next cycle IDLE, o_count 0, o_busy 0. Then re-arm and complete a normal capture.
- i_phase_step=0 → one write per cycle; capture completes in SAMP_DEPTH cycles.
